// File: rtl/main_memory_responder_if.sv
// Request/response bundle between the cache controller (master) and the
// main-memory model (slave).
interface main_memory_responder_if #(
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 32
);
  typedef struct packed {
    logic                    valid;
    logic [ADDR_WIDTH-1:0]   address;
    logic                    wen;
    logic [LINE_WIDTH-1:0]   data;
    logic [LINE_WIDTH/8-1:0] strobe;
  } memory_request_t;

  typedef struct packed {
    logic                  valid;
    logic [LINE_WIDTH-1:0] data;
  } memory_response_t;

  memory_request_t  MemoryRequest;
  memory_response_t MemoryResponse;

  modport master (output MemoryRequest, input MemoryResponse);
  modport slave  (input MemoryRequest, output MemoryResponse);
endinterface

// File: rtl/main_memory_responder.sv
// Fixed-latency main-memory model: one outstanding line read or strobed write.
// Define MEM_RAND_LATENCY_EN to add 0..7 LFSR-driven extra cycles per request.
module main_memory_responder #(
  parameter int LINE_WIDTH = 128,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  main_memory_responder_if.slave   mem,
  output logic                     busy
);
  localparam int STRB_WIDTH  = LINE_WIDTH / 8;
  localparam int OFFSET_BITS = $clog2(STRB_WIDTH);
  localparam int INDEX_BITS  = $clog2(DEPTH);
`ifdef MEM_RAND_LATENCY_EN
  localparam int MAX_WAIT = LATENCY + 7;
`else
  localparam int MAX_WAIT = LATENCY;
`endif
  localparam int CNT_BITS = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  if (LATENCY < 1) begin : g_latency_check
    $error("main_memory_responder: LATENCY must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, BUSY, RESPOND, RELEASE} state_t;

  function automatic logic [LINE_WIDTH-1:0] merge_line(
    input logic [LINE_WIDTH-1:0] old_line,
    input logic [LINE_WIDTH-1:0] new_data,
    input logic [STRB_WIDTH-1:0] strobe
  );
    logic [LINE_WIDTH-1:0] res;
    res = old_line;
    for (int b = 0; b < STRB_WIDTH; b++) begin
      if (strobe[b]) res[b*8 +: 8] = new_data[b*8 +: 8];
      else           res[b*8 +: 8] = old_line[b*8 +: 8];
    end
    return res;
  endfunction

  state_t                  state, state_nxt;
  logic [CNT_BITS-1:0]     cnt, cnt_nxt, cnt_load;
  logic [INDEX_BITS-1:0]   lat_index;
  logic                    lat_wen;
  logic [LINE_WIDTH-1:0]   lat_data;
  logic [STRB_WIDTH-1:0]   lat_strobe;
  logic                    rsp_valid;
  logic [LINE_WIDTH-1:0]   rsp_data;
  logic                    accept, commit;
  logic [LINE_WIDTH-1:0]   line_old, line_new;
  logic [LINE_WIDTH-1:0]   mem_array [DEPTH];
  logic                    unused_addr_bits;

  // Address bits outside the line index are deliberately ignored (aliasing).
  assign unused_addr_bits = ^{mem.MemoryRequest.address[ADDR_WIDTH-1:OFFSET_BITS+INDEX_BITS],
                              mem.MemoryRequest.address[OFFSET_BITS-1:0]};

`ifdef MEM_RAND_LATENCY_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR (taps 16,14,13,11), stepped once per accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         lfsr <= 16'hACE1;
    else if (accept) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    else             lfsr <= lfsr;
  end

  assign cnt_load = CNT_BITS'(LATENCY - 1) + CNT_BITS'(lfsr[2:0]);
`else
  assign cnt_load = CNT_BITS'(LATENCY - 1);
`endif

  assign line_old = mem_array[lat_index];
  assign line_new = lat_wen ? merge_line(line_old, lat_data, lat_strobe) : line_old;

  // Next-state and counter logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (mem.MemoryRequest.valid) begin
          accept    = 1'b1;
          cnt_nxt   = cnt_load;
          state_nxt = BUSY;
        end else begin
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (cnt == {CNT_BITS{1'b0}}) begin
          commit    = 1'b1;
          state_nxt = RESPOND;
        end else begin
          cnt_nxt   = cnt - CNT_BITS'(1);
        end
      end
      RESPOND: begin
        if (mem.MemoryRequest.valid) state_nxt = RELEASE;
        else                         state_nxt = IDLE;
      end
      RELEASE: begin
        if (mem.MemoryRequest.valid) state_nxt = RELEASE;
        else                         state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, latched request and registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= {CNT_BITS{1'b0}};
      lat_index  <= {INDEX_BITS{1'b0}};
      lat_wen    <= 1'b0;
      lat_data   <= {LINE_WIDTH{1'b0}};
      lat_strobe <= {STRB_WIDTH{1'b0}};
      rsp_valid  <= 1'b0;
      rsp_data   <= {LINE_WIDTH{1'b0}};
      busy       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rsp_valid <= commit;
      busy      <= (state_nxt != IDLE);
      if (accept) begin
        lat_index  <= mem.MemoryRequest.address[OFFSET_BITS +: INDEX_BITS];
        lat_wen    <= mem.MemoryRequest.wen;
        lat_data   <= mem.MemoryRequest.data;
        lat_strobe <= mem.MemoryRequest.strobe;
      end
      if (commit) rsp_data <= line_new;
    end
  end

  // Line storage has no reset; a write lands only on its commit edge.
  always_ff @(posedge clk) begin
    if (commit && lat_wen) mem_array[lat_index] <= line_new;
  end

  assign mem.MemoryResponse = {rsp_valid, rsp_data};
endmodule

// File: doc/main_memory_responder.md
Name: main_memory_responder

Overview:
- Behavioural/synthesizable main-memory model at the memory end of the Memory_Request/Memory_Response interface.
- Serves line-sized reads and byte-strobed writes from the cache controller with configurable fixed latency.
- Used as the memory backing store in cache testbenches and FPGA bring-up.
- Single outstanding request; level-held request, single-cycle response pulse.

Parameters:
- LINE_WIDTH, 128: data width of one memory line in bits; multiple of 8; must match the interface_pkg data field.
- DEPTH, 1024: number of lines in the array; power of two.
- LATENCY, 4: cycles from request acceptance to response pulse; must be 1 or more, elaboration error otherwise.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- MemoryRequest  input  Memory_Request  request struct; fields: valid, address, wen, data (LINE_WIDTH), strobe (LINE_WIDTH/8)
- MemoryResponse  output  Memory_Response  response struct; fields: valid, data (LINE_WIDTH)
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: single clock domain on clk; rst is asynchronous, active-high.
- Reset values: state=IDLE, MemoryResponse.valid=0, MemoryResponse.data=0, busy=0, latency counter=0. The memory array is not reset.
- Address map:
  - OFFSET_BITS = log2(LINE_WIDTH/8); INDEX_BITS = log2(DEPTH).
  - index = address[OFFSET_BITS +: INDEX_BITS].
  - Upper address bits are ignored, so addresses alias modulo DEPTH lines.
- States:
  - IDLE: if MemoryRequest.valid is sampled 1, latch address, wen, data and strobe; counter = LATENCY-1; go to BUSY.
  - BUSY: count down each cycle. When counter==0 at a rising edge:
    - Write: commit the byte-strobed write (byte b of the line is updated iff strobe[b]); response data = updated line.
    - Read: response data = stored line.
    - Go to RESPOND.
  - RESPOND: MemoryResponse.valid=1 for exactly one cycle. Next state is RELEASE if MemoryRequest.valid is 1, else IDLE.
  - RELEASE: wait until MemoryRequest.valid is 0, then IDLE. This prevents the still-held request from being re-served.
- Latency: valid sampled at edge N in IDLE, so MemoryResponse.valid is high in the cycle following edge N+LATENCY.
- Response data hold: MemoryResponse.data stays stable from the RESPOND cycle until the next write of response data, including through RELEASE and IDLE. The requester may consume data after the valid pulse.
- Request changes: valid dropping or fields changing during BUSY are ignored; the latched operation completes and the response still pulses.
- Back-to-back requests: at least one IDLE cycle separates responses. A new request in the cycle after RELEASE exits is accepted normally.
- Write then read of the same line: the read returns the merged data. Strobe all-zero write leaves the line unchanged but still responds.
- Reset mid-operation: returns to IDLE immediately. A write whose commit edge has not occurred is lost; committed lines are retained.

Optional Feature:
- Macro: MEM_RAND_LATENCY_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances once per accepted request.
  - Its low 3 bits add 0..7 extra cycles to the counter load, giving effective latency LATENCY..LATENCY+7.
  - All other rules are unchanged.
- Undefined: latency is exactly LATENCY; no LFSR logic is present.

Test Plan:
- Preload line 5 = 128'h00112233_44556677_8899AABB_CCDDEEFF. Read address 0x50, valid held until response → valid pulses 1 cycle exactly 4 cycles after acceptance, data = preload value; data unchanged 3 cycles later.
- Write address 0x50, data all 0xFF bytes, strobe 16'h000F; then read 0x50 → data = 128'h00112233_44556677_8899AABB_FFFFFFFF.
- Read address 0x4050 (aliases to index 5 with DEPTH=1024) → same data as address 0x50.
- Hold valid 3 cycles after the response pulse → exactly one response, busy high until valid drops, then next request accepted → one new response.
- Assert rst asynchronously in BUSY of a write to 0x60 → outputs 0 immediately, no response pulse; read 0x60 returns old contents.
- With MEM_RAND_LATENCY_EN: 8 reads → every latency in [4,11]; sequence identical across two runs from reset.
